// File: rtl/ysyx_24100005_pkg.sv
// Shared types and constants for the ysyx_24100005 instruction fetch unit.
// YSYX_24100005_IFU_MISALIGN_CHK_EN adds the S_HALT state.
package ysyx_24100005_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_NEXT = 3'd3,
        S_HALT = 3'd4
    } ifu_state_e;
`else
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_NEXT = 2'd3
    } ifu_state_e;
`endif

endpackage

// File: rtl/ysyx_24100005_ifu_holdbuf.sv
// Holding registers for the fetched instruction word and its address.
// Each register has its own load enable; both reset asynchronously.
module ysyx_24100005_ifu_holdbuf
    import ysyx_24100005_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_en,
    input  logic [XLEN-1:0] inst_next,
    input  logic            pc_en,
    input  logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst <= '0;
        end else if (inst_en) begin
            inst <= inst_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_en) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: request -> wait -> hold -> next-PC handshake FSM.
// Define YSYX_24100005_IFU_MISALIGN_CHK_EN to trap misaligned targets (S_HALT, fetch_misaligned).
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
    ,
    output logic            fetch_misaligned
`endif
);

    ifu_state_e      state;
    ifu_state_e      state_next;
    logic            inst_en;
    logic            npc_load;
    logic            pc_en;
    logic [XLEN-1:0] pc_target;
    logic            target_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
    assign target_bad = |npc[1:0];
    assign pc_target  = npc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_misaligned <= 1'b0;
        end else if (npc_load && target_bad) begin
            fetch_misaligned <= 1'b1;
        end
    end
`else
    // Without the trap, low address bits are silently cleared.
    assign target_bad = 1'b0;
    assign pc_target  = npc & ~XLEN'(3);
`endif

    always_comb begin
        state_next = state;
        inst_en    = 1'b0;
        npc_load   = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_en    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    if (npc_valid) begin
                        npc_load = 1'b1;
                    end else begin
                        state_next = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (npc_valid) begin
                    npc_load = 1'b1;
                end
            end
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
            S_HALT: begin
                state_next = S_HALT;
            end
`endif
            default: begin
                state_next = S_REQ;
            end
        endcase

        if (npc_load) begin
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
            state_next = target_bad ? S_HALT : S_REQ;
`else
            state_next = S_REQ;
`endif
        end
    end

    assign pc_en = npc_load && !target_bad;

    // Outputs decode the registered state only, so memory inputs never reach them combinationally.
    assign imem_req_valid = (state == S_REQ);
    assign inst_valid     = (state == S_HOLD);
    assign imem_req_addr  = pc;

    ysyx_24100005_ifu_holdbuf #(
        .RESET_PC (RESET_PC)
    ) u_holdbuf (
        .clk       (clk),
        .rst       (rst),
        .inst_en   (inst_en),
        .inst_next (imem_rsp_data),
        .pc_en     (pc_en),
        .pc_next   (pc_target),
        .inst      (inst),
        .pc        (pc)
    );

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Scoreboard bench for ysyx_24100005_ifu: a memory model answers requests, monitors check
// request addresses and delivered instructions against queued expectations.
module tb_ysyx_24100005_ifu;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        npc_valid;
    logic [31:0] npc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
    logic        fetch_misaligned;
`endif

    logic        mem_rsp_valid;
    logic        spur_valid;
    logic        drop_rsp;
    int          mem_lat;
    int          checks;
    int          errors;
    logic [31:0] exp_req_q[$];
    exp_t        exp_inst_q[$];

    assign imem_rsp_valid = mem_rsp_valid | spur_valid;

    ysyx_24100005_ifu #(
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .npc_valid        (npc_valid),
        .npc              (npc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .pc               (pc)
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] word);
        exp_req_q.push_back(addr);
        exp_inst_q.push_back('{pc: addr, inst: word});
    endtask

    task automatic wait_inst(input string name);
        int n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'd0, inst_valid}, 32'd1);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return {a[15:0], 16'h0513};
    endfunction

    // Instruction memory: accepts at the edge, answers mem_lat cycles later; reset drops it.
    always @(posedge rst) drop_rsp = 1'b1;

    initial begin
        logic [31:0] a;
        int          n;
        mem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                a = imem_req_addr;
                n = mem_lat;
                drop_rsp = 1'b0;
                @(posedge clk);
                #1;
                for (int i = 0; i < n && !drop_rsp; i++) begin
                    @(posedge clk);
                    #1;
                end
                if (!drop_rsp && !rst) begin
                    mem_rsp_valid = 1'b1;
                    imem_rsp_data = mem_word(a);
                    @(posedge clk);
                    #1;
                    mem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Request monitor
    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            if (exp_req_q.size() == 0) begin
                check("unexpected_req", imem_req_addr, 32'hxxxx_xxxx);
            end else begin
                check("req_addr", imem_req_addr, exp_req_q.pop_front());
            end
        end
    end

    // Instruction monitor: compares on each rising inst_valid
    logic iv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (inst_valid && !iv_prev) begin
            if (exp_inst_q.size() == 0) begin
                check("unexpected_inst", inst, 32'hxxxx_xxxx);
            end else begin
                e = exp_inst_q.pop_front();
                check("inst_pc", pc, e.pc);
                check("inst_word", inst, e.inst);
            end
        end
        iv_prev = inst_valid;
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        npc_valid      = 1'b0;
        npc            = '0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        spur_valid     = 1'b0;
        mem_lat        = 0;
        repeat (2) tick();

        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h8000_0000);

        // First fetch after reset, zero-wait memory
        push_fetch(32'h8000_0000, 32'h0010_0093);
        rst = 1'b0;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        tick();
        check("lat_c1_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("lat_c1_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("lat_c2_inst_valid", {31'd0, inst_valid}, 32'd1);

        // Decode stalls 5 cycles; npc_valid without handshake must be ignored
        npc_valid = 1'b1;
        npc = 32'h8000_0040;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_inst", inst, 32'h0010_0093);
            check("stall_pc", pc, 32'h8000_0000);
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
        end
        npc_valid = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("next_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("next_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("next_pc_held", pc, 32'h8000_0000);
        push_fetch(32'h8000_0004, 32'h0004_0513);
        npc_valid = 1'b1;
        npc = 32'h8000_0004;
        tick();
        npc_valid = 1'b0;
        check("npc_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("npc_req_addr", imem_req_addr, 32'h8000_0004);
        wait_inst("wait_inst_0004");

        // Handshake and npc together skip S_NEXT; memory then stalls with a spurious response
        push_fetch(32'h8000_0100, 32'h0100_0513);
        inst_ready = 1'b1;
        npc_valid = 1'b1;
        npc = 32'h8000_0100;
        imem_req_ready = 1'b0;
        tick();
        inst_ready = 1'b0;
        npc_valid = 1'b0;
        check("skip_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("skip_req_addr", imem_req_addr, 32'h8000_0100);
        spur_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            spur_valid = 1'b0;
            check("hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("hold_req_addr", imem_req_addr, 32'h8000_0100);
            check("hold_inst_valid", {31'd0, inst_valid}, 32'd0);
            check("hold_inst", inst, 32'h0004_0513);
        end
        imem_req_ready = 1'b1;
        wait_inst("wait_inst_0100");

        // Top-of-address-space target taken as-is
        push_fetch(32'hFFFF_FFFC, 32'hFFFC_0513);
        inst_ready = 1'b1;
        npc_valid = 1'b1;
        npc = 32'hFFFF_FFFC;
        tick();
        inst_ready = 1'b0;
        npc_valid = 1'b0;
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_inst("wait_inst_fffc");

        // Misaligned target
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        npc_valid = 1'b1;
        npc = 32'h8000_0002;
`ifdef YSYX_24100005_IFU_MISALIGN_CHK_EN
        tick();
        npc_valid = 1'b0;
        check("misaligned_flag", {31'd0, fetch_misaligned}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        rst = 1'b1;
        tick();
        check("halt_rst_flag", {31'd0, fetch_misaligned}, 32'd0);
        push_fetch(32'h8000_0000, 32'h0010_0093);
        rst = 1'b0;
`else
        push_fetch(32'h8000_0000, 32'h0010_0093);
        tick();
        npc_valid = 1'b0;
        check("align_pc", pc, 32'h8000_0000);
`endif
        wait_inst("wait_inst_align");

        // Reset during S_WAIT drops the in-flight fetch
        exp_req_q.push_back(32'h8000_0008);
        mem_lat = 3;
        inst_ready = 1'b1;
        npc_valid = 1'b1;
        npc = 32'h8000_0008;
        tick();
        inst_ready = 1'b0;
        npc_valid = 1'b0;
        check("pre_wait_pc", pc, 32'h8000_0008);
        tick();
        check("in_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 32'h8000_0000);
        check("async_rst_inst", inst, 32'h0);
        check("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        mem_lat = 0;
        push_fetch(32'h8000_0000, 32'h0010_0093);
        repeat (3) tick();
        rst = 1'b0;
        wait_inst("wait_inst_after_rst");

        repeat (2) tick();
        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("inst_queue_empty", exp_inst_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
